// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Arbitrates the single register-file write port between the EX (ALU) and
//   MEM (load) writeback requesters. MEM normally has fixed priority. After
//   STARVE_MAX consecutive blocked EX cycles the arbiter switches to an
//   override state in which EX wins once. The write port outputs are registered,
//   so a transfer in cycle N appears on wb_* in cycle N+1.
//
//   Handshake (both requesters): a transfer happens in any cycle where
//   valid & ready. ready is combinational from the current valid inputs and the
//   arbiter state. While valid & !ready the requester holds rd/data stable and
//   keeps valid high; it may drop valid without a transfer only on flush.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous pipeline flush, blocks all grants
//   ex_valid/rd/data    EX writeback request
//   ex_ready            EX accepted this cycle
//   mem_valid/rd/data   MEM writeback request
//   mem_ready           MEM accepted this cycle
//   wb_en/wb_reg/wb_val registered regfile write port
//   ex_forced           EX is winning through the starvation override
//   dbg_state           current arbiter state (PRI_MEM=0, PRI_EX=1)
//   dbg_starve_cnt      current starvation counter
module regfile_wb_arbiter #(
   parameter int XLEN       = 32,
   parameter int STARVE_MAX = 4,
   parameter int CW         = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            ex_valid,
   input  logic [4:0]      ex_rd,
   input  logic [XLEN-1:0] ex_data,
   output logic            ex_ready,
   input  logic            mem_valid,
   input  logic [4:0]      mem_rd,
   input  logic [XLEN-1:0] mem_data,
   output logic            mem_ready,
   output logic            wb_en,
   output logic [4:0]      wb_reg,
   output logic [XLEN-1:0] wb_val,
   output logic            ex_forced,
   output logic            dbg_state,
   output logic [CW-1:0]   dbg_starve_cnt
);

   localparam logic [0:0]    PRI_MEM    = 1'b0;
   localparam logic [0:0]    PRI_EX     = 1'b1;
   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

   logic [0:0]    state, state_nxt;
   logic [CW-1:0] starve_cnt, starve_nxt;
   logic          ex_xfer, mem_xfer, ex_blocked;

   // Grant logic. Reset and flush both suppress every grant.
   always_comb begin
      ex_ready  = 1'b0;
      mem_ready = 1'b0;
      ex_forced = 1'b0;
      if (rst_n && !flush) begin
         if (state == PRI_EX) begin
            ex_ready  = ex_valid;
            mem_ready = mem_valid & ~ex_valid;
            ex_forced = ex_valid;
         end else begin
            mem_ready = mem_valid;
            ex_ready  = ex_valid & ~mem_valid;
         end
      end
   end

   assign ex_xfer    = ex_valid & ex_ready;
   assign mem_xfer   = mem_valid & mem_ready;
   assign ex_blocked = ex_valid & ~ex_ready & ~flush;

   // Starvation counter: counts consecutive blocked EX cycles, saturating.
   always_comb begin
      starve_nxt = starve_cnt;
      if (flush || !ex_valid || ex_xfer) begin
         starve_nxt = '0;
      end else if (ex_blocked && (starve_cnt != STARVE_LIM)) begin
         starve_nxt = starve_cnt + 1'b1;
      end
   end

   // The override is entered at the end of the cycle that brings the blocked
   // count up to STARVE_MAX, so EX wins in the following cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         PRI_MEM: if (ex_blocked && ((starve_cnt + 1'b1) == STARVE_LIM)) state_nxt = PRI_EX;
         PRI_EX:  if (flush || ex_xfer) state_nxt = PRI_MEM;
         default: state_nxt = PRI_MEM;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= PRI_MEM;
         starve_cnt <= '0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
      end
   end

   // Registered write port. x0 writes complete the handshake and update
   // wb_reg/wb_val, but never raise wb_en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_en  <= 1'b0;
         wb_reg <= '0;
         wb_val <= '0;
      end else if (mem_xfer) begin
         wb_en  <= (mem_rd != 5'd0);
         wb_reg <= mem_rd;
         wb_val <= mem_data;
      end else if (ex_xfer) begin
         wb_en  <= (ex_rd != 5'd0);
         wb_reg <= ex_rd;
         wb_val <= ex_data;
      end else begin
         wb_en  <= 1'b0;
      end
   end

   assign dbg_state      = state;
   assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Directed scenarios followed by a randomized phase, all checked against a
//   behavioural model that tracks the run of blocked EX cycles and the
//   expected regfile writes.
module tb_regfile_wb_arbiter;
   localparam int XLEN       = 32;
   localparam int STARVE_MAX = 4;
   localparam int CW         = 4;
   localparam int WW         = 1 + 5 + XLEN;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            flush;
   logic            ex_valid, mem_valid;
   logic [4:0]      ex_rd, mem_rd;
   logic [XLEN-1:0] ex_data, mem_data;
   logic            ex_ready, mem_ready, ex_forced;
   logic            wb_en;
   logic [4:0]      wb_reg;
   logic [XLEN-1:0] wb_val;
   logic            dbg_state;
   logic [CW-1:0]   dbg_starve_cnt;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   int              run;        // consecutive blocked EX cycles, capped
   logic            m_en;
   logic [4:0]      m_reg;
   logic [XLEN-1:0] m_val;
   logic            ex_acc, mem_acc;
   logic            obs_ex_ready;
   logic [WW-1:0]   exp_q[$];

   regfile_wb_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
      .wb_en(wb_en), .wb_reg(wb_reg), .wb_val(wb_val), .ex_forced(ex_forced),
      .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
   );

   // Clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      run    = 0;
      m_en   = 1'b0;
      m_reg  = '0;
      m_val  = '0;
      ex_acc = 1'b0;
      mem_acc = 1'b0;
      exp_q.delete();
   endtask

   function automatic logic [4:0] rand_rd();
      if ($urandom_range(0, 7) == 0) return 5'd0;
      return 5'($urandom_range(1, 31));
   endfunction

   // One clock cycle. Called just after a negedge with inputs already driven.
   task automatic step();
      logic          ov, e_exr, e_memr, e_f;
      logic [WW-1:0] w;
      #2;
      // EX has been blocked STARVE_MAX times in a row: it must win now.
      ov     = (run == STARVE_MAX);
      e_exr  = !flush && ex_valid && (ov || !mem_valid);
      e_memr = !flush && mem_valid && !(ov && ex_valid);
      e_f    = ov && ex_valid && !flush;
      check("ex_ready", 64'(ex_ready), 64'(e_exr));
      check("mem_ready", 64'(mem_ready), 64'(e_memr));
      check("ex_forced", 64'(ex_forced), 64'(e_f));
      obs_ex_ready = ex_ready;
      if (e_memr) begin
         m_en = (mem_rd != 0); m_reg = mem_rd; m_val = mem_data;
      end else if (e_exr) begin
         m_en = (ex_rd != 0); m_reg = ex_rd; m_val = ex_data;
      end else begin
         m_en = 1'b0;
      end
      exp_q.push_back({m_en, m_reg, m_val});
      if (flush || !ex_valid || e_exr) run = 0;
      else if (run < STARVE_MAX) run++;
      ex_acc  = e_exr;
      mem_acc = e_memr;
      @(posedge clk);
      #1;
      w = exp_q.pop_front();
      check("wb_en", 64'(wb_en), 64'(w[WW-1]));
      check("wb_reg", 64'(wb_reg), 64'(w[WW-2 -: 5]));
      check("wb_val", 64'(wb_val), 64'(w[XLEN-1:0]));
      check("starve_cnt", 64'(dbg_starve_cnt), 64'(run));
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      flush = 0; ex_valid = 0; mem_valid = 0;
      ex_rd = '0; mem_rd = '0; ex_data = '0; mem_data = '0;
   endtask

   initial begin
      int n;
      idle_inputs();
      model_reset();
      // Reset: ready stays low even with a valid request present
      rst_n = 0;
      ex_valid = 1; ex_rd = 5'd7; ex_data = 32'h1111;
      #3;
      check("rst_ex_ready", 64'(ex_ready), 64'd0);
      check("rst_wb_en", 64'(wb_en), 64'd0);
      check("rst_wb_reg", 64'(wb_reg), 64'd0);
      check("rst_wb_val", 64'(wb_val), 64'd0);
      check("rst_state", 64'(dbg_state), 64'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1;
      idle_inputs();
      step();

      // EX alone
      ex_valid = 1; ex_rd = 5'd5; ex_data = 32'hDEADBEEF;
      step();
      idle_inputs();
      step();

      // Contention: MEM first, EX next
      mem_valid = 1; mem_rd = 5'd3; mem_data = 32'h0000_0333;
      ex_valid  = 1; ex_rd  = 5'd4; ex_data  = 32'h0000_0444;
      step();
      mem_valid = 0;
      step();
      idle_inputs();
      step();

      // Starvation: EX must be granted on the 5th cycle
      ex_valid = 1; ex_rd = 5'd12; ex_data = 32'hCAFE_0012;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         mem_valid = 1; mem_rd = rand_rd(); mem_data = $urandom();
         step();
         n = i + 1;
         if (obs_ex_ready) break;
      end
      check("starve_grant_cycle", 64'(n), 64'd5);
      ex_valid = 0;
      step();
      check("state_after_force", 64'(dbg_state), 64'd0);
      idle_inputs();
      step();

      // x0 write: handshake completes, no write enable
      ex_valid = 1; ex_rd = 5'd0; ex_data = 32'h1234;
      step();
      check("x0_wb_en", 64'(wb_en), 64'd0);
      idle_inputs();
      step();

      // Flush with starve_cnt=3
      ex_valid = 1; ex_rd = 5'd9; ex_data = 32'h99;
      mem_valid = 1; mem_rd = 5'd10; mem_data = 32'hA0;
      step();
      mem_rd = 5'd11; mem_data = 32'hB0; step();
      mem_rd = 5'd13; mem_data = 32'hD0; step();
      check("pre_flush_cnt", 64'(dbg_starve_cnt), 64'd3);
      flush = 1;
      step();
      check("flush_state", 64'(dbg_state), 64'd0);
      check("flush_cnt", 64'(dbg_starve_cnt), 64'd0);
      idle_inputs();
      step();

      // Randomized traffic obeying the handshake rules
      for (int c = 0; c < 400; c++) begin
         logic prev_flush;
         prev_flush = flush;
         if (!ex_valid || ex_acc || prev_flush) begin
            ex_valid = ($urandom_range(0, 2) != 0);
            ex_rd = rand_rd(); ex_data = $urandom();
         end
         if (!mem_valid || mem_acc || prev_flush) begin
            mem_valid = ($urandom_range(0, 3) != 0);
            mem_rd = rand_rd(); mem_data = $urandom();
         end
         flush = ($urandom_range(0, 19) == 0);
         step();
      end
      idle_inputs();
      step();

      // Asynchronous reset mid-cycle while a write is registered
      ex_valid = 1; ex_rd = 5'd21; ex_data = 32'h5A5A_A5A5;
      step();
      check("pre_reset_wb_en", 64'(wb_en), 64'd1);
      #2;
      rst_n = 0;
      #1;
      check("async_wb_en", 64'(wb_en), 64'd0);
      check("async_wb_reg", 64'(wb_reg), 64'd0);
      check("async_wb_val", 64'(wb_val), 64'd0);
      check("async_ex_ready", 64'(ex_ready), 64'd0);
      @(negedge clk);
      rst_n = 1;
      model_reset();
      idle_inputs();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
